// File: rtl/display_scan_ctrl.sv
// Scan sequencer for a 4-digit multiplexed 7-segment display.
// Walks digits 3,2,1,0 with a blanking gap before each digit lights, and
// double-buffers the displayed value so that updates land only at a frame boundary.
module display_scan_ctrl #(
   parameter int unsigned DIV_COUNT    = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       load,
   output logic       ready,
   input  logic [3:0] num2_in,
   input  logic [3:0] num1_in,
   input  logic [3:0] num0_in,
   input  logic       neg_in,
   output logic [1:0] digit,
   output logic [3:0] num2,
   output logic [3:0] num1,
   output logic [3:0] num0,
   output logic       neg,
   output logic [3:0] digit_en,
   output logic       frame_tick
);

   localparam int unsigned MaxCnt = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
   localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

   localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
   localparam logic [CntW-1:0] OnLast    = CntW'(DIV_COUNT - 1);

   typedef enum logic [0:0] {StBlank, StOn} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      digit_q, digit_d;
   logic [3:0]      digit_en_q, digit_en_d;
   logic            frame_tick_q, frame_tick_d;
   logic            commit_q, commit_d;
   logic            pend_full_q, pend_full_d;
   logic [3:0]      pend2_q, pend2_d, pend1_q, pend1_d, pend0_q, pend0_d;
   logic            pend_neg_q, pend_neg_d;
   logic [3:0]      num2_q, num2_d, num1_q, num1_d, num0_q, num0_d;
   logic            neg_q, neg_d;
   logic            wrap;

   // Next-state for the slot FSM, handshake buffer and committed value
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CntW'(1);
      digit_d      = digit_q;
      pend_full_d  = pend_full_q;
      pend2_d      = pend2_q;
      pend1_d      = pend1_q;
      pend0_d      = pend0_q;
      pend_neg_d   = pend_neg_q;
      num2_d       = num2_q;
      num1_d       = num1_q;
      num0_d       = num0_q;
      neg_d        = neg_q;

      unique case (state_q)
         StBlank: begin
            if (cnt_q == BlankLast) begin
               state_d = StOn;
               cnt_d   = '0;
            end
         end
         StOn: begin
            if (cnt_q == OnLast) begin
               state_d = StBlank;
               cnt_d   = '0;
               digit_d = digit_q - 2'd1;  // 0 wraps to 3
            end
         end
         default: begin
            state_d = StBlank;
            cnt_d   = '0;
         end
      endcase

      wrap         = (state_q == StOn) && (cnt_q == OnLast) && (digit_q == 2'd0);
      frame_tick_d = wrap;
      commit_d     = wrap && pend_full_q;

      if (commit_d) begin
         num2_d = pend2_q;
         num1_d = pend1_q;
         num0_d = pend0_q;
         neg_d  = pend_neg_q;
      end

      // Buffer frees one cycle after the commit edge; pending is still full
      // during that cycle, so a new load cannot collide with the clear.
      if (commit_q) begin
         pend_full_d = 1'b0;
      end

      if (load && !pend_full_q) begin
         pend_full_d = 1'b1;
         pend2_d     = num2_in;
         pend1_d     = num1_in;
         pend0_d     = num0_in;
         pend_neg_d  = neg_in;
      end

      // Anodes derived from next state so the output is a clean flop
      if (state_d == StOn && enable) begin
         digit_en_d = ~(4'b0001 << digit_d);
      end else begin
         digit_en_d = 4'b1111;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StBlank;
         cnt_q        <= '0;
         digit_q      <= 2'd3;
         digit_en_q   <= 4'b1111;
         frame_tick_q <= 1'b0;
         commit_q     <= 1'b0;
         pend_full_q  <= 1'b0;
         pend2_q      <= '0;
         pend1_q      <= '0;
         pend0_q      <= '0;
         pend_neg_q   <= 1'b0;
         num2_q       <= '0;
         num1_q       <= '0;
         num0_q       <= '0;
         neg_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         digit_q      <= digit_d;
         digit_en_q   <= digit_en_d;
         frame_tick_q <= frame_tick_d;
         commit_q     <= commit_d;
         pend_full_q  <= pend_full_d;
         pend2_q      <= pend2_d;
         pend1_q      <= pend1_d;
         pend0_q      <= pend0_d;
         pend_neg_q   <= pend_neg_d;
         num2_q       <= num2_d;
         num1_q       <= num1_d;
         num0_q       <= num0_d;
         neg_q        <= neg_d;
      end
   end

   assign ready      = !pend_full_q;
   assign digit      = digit_q;
   assign digit_en   = digit_en_q;
   assign frame_tick = frame_tick_q;
   assign num2       = num2_q;
   assign num1       = num1_q;
   assign num0       = num0_q;
   assign neg        = neg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DIV_COUNT=4, BLANK_CYCLES=2.
// Slot = 6 clk, frame = 24 clk; cyc 0 is the first cycle after reset release.
module tb_display_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset, enable, load, ready, neg_in, neg, frame_tick;
   logic [3:0] num2_in, num1_in, num0_in, num2, num1, num0, digit_en;
   logic [1:0] digit;

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   display_scan_ctrl #(
      .DIV_COUNT   (4),
      .BLANK_CYCLES(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .load      (load),
      .ready     (ready),
      .num2_in   (num2_in),
      .num1_in   (num1_in),
      .num0_in   (num0_in),
      .neg_in    (neg_in),
      .digit     (digit),
      .num2      (num2),
      .num1      (num1),
      .num0      (num0),
      .neg       (neg),
      .digit_en  (digit_en),
      .frame_tick(frame_tick)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [15:0] val();
      return {3'b000, neg, num2, num1, num0};
   endfunction

   task automatic drive_load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                             input logic n);
      load    = 1'b1;
      num2_in = a;
      num1_in = b;
      num0_in = c;
      neg_in  = n;
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; load = 1'b0;
      num2_in = '0; num1_in = '0; num0_in = '0; neg_in = 1'b0;
      tick(); tick();
      chk("rst_digit", 16'(digit), 16'd3);
      chk("rst_en", 16'(digit_en), 16'hf);
      chk("rst_val", val(), 16'h0000);
      chk("rst_ready", 16'(ready), 16'd1);
      chk("rst_tick", 16'(frame_tick), 16'd0);
      reset = 1'b0;
      cyc   = 0;

      // Scan timing from reset release
      chk("c0_en", 16'(digit_en), 16'hf);
      wait_to(1);  chk("c1_en", 16'(digit_en), 16'hf);
      wait_to(2);  chk("c2_en", 16'(digit_en), 16'h7);
      chk("c2_digit", 16'(digit), 16'd3);
      wait_to(5);  chk("c5_en", 16'(digit_en), 16'h7);
      wait_to(6);  chk("c6_en", 16'(digit_en), 16'hf);
      chk("c6_digit", 16'(digit), 16'd2);
      wait_to(8);  chk("c8_en", 16'(digit_en), 16'hb);
      wait_to(14); chk("c14_en", 16'(digit_en), 16'hd);
      chk("c14_digit", 16'(digit), 16'd1);
      wait_to(20); chk("c20_en", 16'(digit_en), 16'he);
      chk("c20_digit", 16'(digit), 16'd0);
      wait_to(23); chk("c23_tick", 16'(frame_tick), 16'd0);
      wait_to(24); chk("c24_tick", 16'(frame_tick), 16'd1);
      chk("c24_digit", 16'(digit), 16'd3);
      chk("c24_en", 16'(digit_en), 16'hf);
      wait_to(25); chk("c25_tick", 16'(frame_tick), 16'd0);

      // Load {2,5,7,neg}; a second load while busy is dropped
      drive_load(4'd2, 4'd5, 4'd7, 1'b1);
      wait_to(26); chk("ld_ready0", 16'(ready), 16'd0);
      drive_load(4'd9, 4'd9, 4'd9, 1'b0);
      wait_to(27); load = 1'b0;
      wait_to(47); chk("pre_commit_val", val(), 16'h0000);
      chk("pre_commit_ready", 16'(ready), 16'd0);
      wait_to(48); chk("commit_tick", 16'(frame_tick), 16'd1);
      chk("commit_val", val(), 16'h1257);
      chk("commit_ready_lag", 16'(ready), 16'd0);
      wait_to(49); chk("ready_back", 16'(ready), 16'd1);

      // Load on the frame_tick cycle commits a full frame later
      wait_to(72); chk("c72_tick", 16'(frame_tick), 16'd1);
      drive_load(4'd3, 4'd1, 4'd4, 1'b0);
      wait_to(73); load = 1'b0;
      chk("c73_ready", 16'(ready), 16'd0);
      chk("c73_val", val(), 16'h1257);
      wait_to(95); chk("c95_val", val(), 16'h1257);
      wait_to(96); chk("c96_val", val(), 16'h0314);

      // Load on the wrap cycle with pending empty waits for the next boundary
      wait_to(119); drive_load(4'd6, 4'd0, 4'd8, 1'b1);
      wait_to(120); load = 1'b0;
      chk("c120_tick", 16'(frame_tick), 16'd1);
      chk("c120_val", val(), 16'h0314);
      chk("c120_ready", 16'(ready), 16'd0);
      wait_to(143); chk("c143_val", val(), 16'h0314);
      wait_to(144); chk("c144_val", val(), 16'h1608);

      // A frame with enable low: anodes dark, scan unchanged
      enable = 1'b0;
      wait_to(146); chk("dis_en_d3", 16'(digit_en), 16'hf);
      chk("dis_digit3", 16'(digit), 16'd3);
      wait_to(152); chk("dis_digit2", 16'(digit), 16'd2);
      wait_to(158); chk("dis_en_d1", 16'(digit_en), 16'hf);
      chk("dis_digit1", 16'(digit), 16'd1);
      wait_to(164); chk("dis_en_d0", 16'(digit_en), 16'hf);
      wait_to(168); chk("dis_tick", 16'(frame_tick), 16'd1);
      enable = 1'b1;
      wait_to(170); chk("reen_en", 16'(digit_en), 16'h7);

      // Reset during digit 1 ON with pending full
      drive_load(4'd1, 4'd2, 4'd3, 1'b0);
      wait_to(171); load = 1'b0;
      chk("c171_ready", 16'(ready), 16'd0);
      wait_to(183); chk("c183_en", 16'(digit_en), 16'hd);
      reset = 1'b1;
      wait_to(184);
      chk("mrst_digit", 16'(digit), 16'd3);
      chk("mrst_en", 16'(digit_en), 16'hf);
      chk("mrst_val", val(), 16'h0000);
      chk("mrst_ready", 16'(ready), 16'd1);
      chk("mrst_tick", 16'(frame_tick), 16'd0);
      reset = 1'b0;
      cyc   = 0;
      wait_to(2);  chk("r2_en", 16'(digit_en), 16'h7);
      wait_to(24); chk("r24_tick", 16'(frame_tick), 16'd1);
      chk("r24_val_discarded", val(), 16'h0000);
      chk("r24_ready", 16'(ready), 16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
